// File: rtl/sram_bridge.sv
// rtl/sram_bridge.sv - Wishbone classic slave to async cellular RAM bridge
// Optional single-entry read buffer enabled by defining SRAM_BRIDGE_RDBUF_EN.
module sram_bridge #(
    parameter int WAIT_STATES = 4
) (
    input  logic        clk_i,
    input  logic        res_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [14:0] adr_i,
    input  logic [1:0]  sel_i,
    input  logic [15:0] dat_i,
    output logic [15:0] dat_o,
    output logic        ack_o,
    output logic [14:0] sram_a_o,
    output logic [15:0] sram_d_o,
    input  logic [15:0] sram_d_i,
    output logic        sram_d_oe_o,
    output logic        sram_ce_no,
    output logic        sram_oe_no,
    output logic        sram_we_no,
    output logic        sram_lb_no,
    output logic        sram_ub_no,
    output logic        sram_adv_no,
    output logic        sram_clk_o,
    output logic        sram_cre_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_SETUP, S_WR, S_HOLD, S_ACK
    } state_t;

    localparam logic [3:0] WC_INIT = 4'(WAIT_STATES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_wc;
    logic [14:0] r_a;
    logic [15:0] r_d;
    logic [1:0]  r_sel;
    logic [15:0] r_dat;
    logic        r_ack;
    logic        r_abort;
    logic        r_ce_n, r_oe_n, r_we_n, r_lb_n, r_ub_n, r_d_oe;

    logic        w_req;
    logic        w_hit;
    logic        w_abort;
    logic        w_act;
    logic [1:0]  w_sel;

`ifdef SRAM_BRIDGE_RDBUF_EN
    logic        r_buf_valid;
    logic [14:0] r_buf_adr;
    logic [15:0] r_buf_dat;
    assign w_hit = r_buf_valid && (r_buf_adr == adr_i);
`else
    assign w_hit = 1'b0;
`endif

    assign w_req = (r_state == S_IDLE) && cyc_i && stb_i && !r_ack;
    // Once the master lets go of cyc_i, the access runs to completion but stays silent.
    assign w_abort = (r_state == S_IDLE) ? 1'b0 : (r_abort | ~cyc_i);
    assign w_sel   = (r_state == S_IDLE) ? sel_i : r_sel;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req) w_next = we_i ? S_SETUP : (w_hit ? S_ACK : S_RD);
            S_RD:    if (r_wc == 4'd0) w_next = S_ACK;
            S_SETUP: w_next = S_WR;
            S_WR:    if (r_wc == 4'd0) w_next = S_HOLD;
            S_HOLD:  w_next = S_IDLE;
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_act = (w_next == S_RD) || (w_next == S_SETUP) ||
                   (w_next == S_WR) || (w_next == S_HOLD);

    // Pin registers are loaded from the next state so strobes align with the state they belong to.
    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            r_state <= S_IDLE;
            r_wc    <= 4'd0;
            r_a     <= '0;
            r_d     <= '0;
            r_sel   <= '0;
            r_dat   <= '0;
            r_ack   <= 1'b0;
            r_abort <= 1'b0;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_lb_n  <= 1'b1;
            r_ub_n  <= 1'b1;
            r_d_oe  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_abort <= w_abort;
            if (w_req) begin
                r_a   <= adr_i;
                r_d   <= dat_i;
                r_sel <= sel_i;
                r_wc  <= WC_INIT;
            end else if ((r_state == S_RD || r_state == S_WR) && r_wc != 4'd0) begin
                r_wc <= r_wc - 4'd1;
            end
            r_ce_n <= ~w_act;
            r_oe_n <= ~(w_next == S_RD);
            r_we_n <= ~(w_next == S_WR);
            r_d_oe <= (w_next == S_SETUP) || (w_next == S_WR) || (w_next == S_HOLD);
            r_lb_n <= ~(w_act & w_sel[0]);
            r_ub_n <= ~(w_act & w_sel[1]);
            r_ack  <= ((w_next == S_HOLD) || (w_next == S_ACK)) & ~w_abort;
            if (r_state == S_RD && r_wc == 4'd0)
                r_dat <= sram_d_i;
`ifdef SRAM_BRIDGE_RDBUF_EN
            else if (w_req && !we_i && w_hit)
                r_dat <= r_buf_dat;
`endif
        end
    end

`ifdef SRAM_BRIDGE_RDBUF_EN
    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            r_buf_valid <= 1'b0;
            r_buf_adr   <= '0;
            r_buf_dat   <= '0;
        end else if (r_state == S_RD && r_wc == 4'd0) begin
            r_buf_valid <= 1'b1;
            r_buf_adr   <= r_a;
            r_buf_dat   <= sram_d_i;
        end else if (w_req && we_i && (adr_i == r_buf_adr)) begin
            r_buf_valid <= 1'b0;
        end
    end
`endif

    assign dat_o       = r_dat;
    assign ack_o       = r_ack;
    assign sram_a_o    = r_a;
    assign sram_d_o    = r_d;
    assign sram_d_oe_o = r_d_oe;
    assign sram_ce_no  = r_ce_n;
    assign sram_oe_no  = r_oe_n;
    assign sram_we_no  = r_we_n;
    assign sram_lb_no  = r_lb_n;
    assign sram_ub_no  = r_ub_n;
    assign sram_adv_no = 1'b0;
    assign sram_clk_o  = 1'b0;
    assign sram_cre_o  = 1'b0;

endmodule
